// File: rtl/flag_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// flag_update_ctrl_if
//   Bundles the flag-update port, the condition-check port and the committed
//   flags between the execute/issue logic (master) and flag_update_ctrl (slave).
//
//   Handshake rule for both request ports: a request is taken on a rising
//   clock edge where valid and ready are both high.  The requester keeps
//   valid and its data stable until then.  ready never depends on the same
//   port's valid.  The one cross-port dependency is cond_ready, which drops
//   while upd_valid is high, so an update always wins a tie.
//
//   Signals:
//     upd_valid/upd_ready   flag-update handshake
//     upd_result            ALU result (N and Z source)
//     upd_carry, upd_ovf    ALU carry-out / signed overflow (C and V source)
//     upd_mask              per-flag write enable {N,Z,C,V}
//     cond_valid/cond_ready condition-check handshake
//     cond_code             ARM condition code 0..15
//     cond_done             one-cycle pulse, cond_pass is valid
//     cond_pass             check result, held until the next cond_done
//     flags                 committed {N,Z,C,V}
//     save_req/restore_req  only with FLAG_SAVE_EN: save / restore flags
// ---------------------------------------------------------------------------
interface flag_update_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              upd_valid;
    logic              upd_ready;
    logic [DATA_W-1:0] upd_result;
    logic              upd_carry;
    logic              upd_ovf;
    logic [3:0]        upd_mask;
    logic              cond_valid;
    logic              cond_ready;
    logic [3:0]        cond_code;
    logic              cond_done;
    logic              cond_pass;
    logic [3:0]        flags;
`ifdef FLAG_SAVE_EN
    logic              save_req;
    logic              restore_req;
`endif

    modport master (
        output upd_valid, upd_result, upd_carry, upd_ovf, upd_mask,
        output cond_valid, cond_code,
`ifdef FLAG_SAVE_EN
        output save_req, restore_req,
`endif
        input  upd_ready, cond_ready, cond_done, cond_pass, flags
    );

    modport slave (
        input  upd_valid, upd_result, upd_carry, upd_ovf, upd_mask,
        input  cond_valid, cond_code,
`ifdef FLAG_SAVE_EN
        input  save_req, restore_req,
`endif
        output upd_ready, cond_ready, cond_done, cond_pass, flags
    );
endinterface

// File: rtl/flag_update_ctrl.sv
// ---------------------------------------------------------------------------
// flag_update_ctrl
//   Owns the architectural NZCV status register and sequences every write to
//   it.  An accepted update is staged in IDLE and written in COMMIT, so new
//   flags are visible after the second edge.  Condition checks are only taken
//   in IDLE with no update pending, so they always see committed flags.
//
//   Optional feature macro: FLAG_SAVE_EN
//     Adds a saved-flags register plus save_req / restore_req.  Priority in
//     IDLE is restore_req > save_req > upd_valid > cond_valid.
//
//   Ports:
//     clk       system clock, rising edge
//     reset     asynchronous, active-high; clears all state
//     bus       flag_update_ctrl_if.slave (update/check ports, flags)
//     dbgState  FSM state, 1 while in COMMIT
// ---------------------------------------------------------------------------
module flag_update_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    flag_update_ctrl_if.slave       bus,
    output logic                    dbgState
);

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] flagsQ;
    logic [3:0] stagedFlags;
    logic [3:0] stagedMask;
    logic       condDone;
    logic       condPass;

    logic       higherPending;
    logic       updFire;
    logic       condFire;
    logic       newN;
    logic       newZ;

`ifdef FLAG_SAVE_EN
    logic [3:0] savedFlags;
    logic       saveFire;
    logic       restoreFire;

    // Save/restore outrank both request ports and block their ready.
    assign higherPending = bus.restore_req | bus.save_req;
    assign restoreFire   = (state == IDLE) & bus.restore_req;
    assign saveFire      = (state == IDLE) & ~bus.restore_req & bus.save_req;
`else
    assign higherPending = 1'b0;
`endif

    assign bus.upd_ready  = (state == IDLE) & ~higherPending;
    // An update in the same cycle wins; the check waits until it commits.
    assign bus.cond_ready = (state == IDLE) & ~higherPending & ~bus.upd_valid;

    assign updFire  = bus.upd_valid  & bus.upd_ready;
    assign condFire = bus.cond_valid & bus.cond_ready;

    // N is the sign bit of the result, Z is a full-width zero test.
    assign newN = bus.upd_result[DATA_W-1];
    assign newZ = (bus.upd_result == {DATA_W{1'b0}});

    assign bus.flags     = flagsQ;
    assign bus.cond_done = condDone;
    assign bus.cond_pass = condPass;
    assign dbgState      = (state == COMMIT);

    // ARM condition evaluation against {N,Z,C,V}.
    function automatic logic condEval(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            4'd0:    r = z;
            4'd1:    r = ~z;
            4'd2:    r = c;
            4'd3:    r = ~c;
            4'd4:    r = n;
            4'd5:    r = ~n;
            4'd6:    r = v;
            4'd7:    r = ~v;
            4'd8:    r = c & ~z;
            4'd9:    r = ~c | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = ~z & (n == v);
            4'd13:   r = z | (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            flagsQ      <= 4'h0;
            stagedFlags <= 4'h0;
            stagedMask  <= 4'h0;
            condDone    <= 1'b0;
            condPass    <= 1'b0;
`ifdef FLAG_SAVE_EN
            savedFlags  <= 4'h0;
`endif
        end else begin
            condDone <= 1'b0;
            case (state)
                IDLE: begin
`ifdef FLAG_SAVE_EN
                    if (restoreFire) begin
                        stagedFlags <= savedFlags;
                        stagedMask  <= 4'hF;
                        state       <= COMMIT;
                    end else if (saveFire) begin
                        savedFlags  <= flagsQ;
                    end else
`endif
                    if (updFire) begin
                        stagedFlags <= {newN, newZ, bus.upd_carry, bus.upd_ovf};
                        stagedMask  <= bus.upd_mask;
                        state       <= COMMIT;
                    end else if (condFire) begin
                        condDone <= 1'b1;
                        condPass <= condEval(flagsQ, bus.cond_code);
                    end
                end
                COMMIT: begin
                    // Masked merge: unwritten flags keep their value.
                    flagsQ <= (flagsQ & ~stagedMask) | (stagedFlags & stagedMask);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_update_ctrl.sv
module tb_flag_update_ctrl;

    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic dbgState;

    always #5 clk = ~clk;

    flag_update_ctrl_if #(.DATA_W(DATA_W)) ifc ();

    flag_update_ctrl #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (ifc.slave),
        .dbgState (dbgState)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] modelFlags = 4'h0;
    logic [3:0] savedModel = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags written bit by bit from the ALU outputs.
    function automatic logic [3:0] modelUpdate(input logic [3:0] old, input logic [31:0] r,
                                               input logic c, input logic o, input logic [3:0] m);
        logic [3:0] nv;
        logic [3:0] res;
        nv[3] = ($signed(r) < 0);
        nv[2] = (r == 0);
        nv[1] = c;
        nv[0] = o;
        for (int i = 0; i < 4; i++) res[i] = m[i] ? nv[i] : old[i];
        return res;
    endfunction

    // Reference model: even codes give the base test, odd codes its inverse.
    function automatic logic modelCond(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (code % 2 == 1) ? !base : base;
    endfunction

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic doUpdate(input logic [31:0] r, input logic c, input logic o, input logic [3:0] m);
        int budget;
        logic [3:0] oldFlags;
        ifc.upd_valid  = 1'b1;
        ifc.upd_result = r;
        ifc.upd_carry  = c;
        ifc.upd_ovf    = o;
        ifc.upd_mask   = m;
        budget = 0;
        while (!ifc.upd_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("upd_ready_wait", ifc.upd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ifc.upd_valid = 1'b0;
        oldFlags   = modelFlags;
        modelFlags = modelUpdate(modelFlags, r, c, o, m);
        check("commit_upd_ready", ifc.upd_ready, 0);
        check("flags_before_commit", ifc.flags, oldFlags);
        @(negedge clk);
        check("flags_after_commit", ifc.flags, modelFlags);
    endtask

    task automatic doCond(input logic [3:0] code);
        int budget;
        ifc.cond_valid = 1'b1;
        ifc.cond_code  = code;
        budget = 0;
        while (!ifc.cond_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("cond_ready_wait", ifc.cond_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ifc.cond_valid = 1'b0;
        check("cond_done_pulse", ifc.cond_done, 1);
        check("cond_pass", ifc.cond_pass, modelCond(modelFlags, code));
        @(negedge clk);
        check("cond_done_drop", ifc.cond_done, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] result;
        logic        carry;
        logic        ovf;
        logic [3:0]  mask;
        logic [3:0]  condCode;
        logic [3:0]  expFlags;
        logic        expPass;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] sweepExp;

        vecs[0] = '{32'h8000_0000, 1'b1, 1'b0, 4'hF, 4'd4,  4'b1010, 1'b1}; // MI
        vecs[1] = '{32'h0000_0000, 1'b1, 1'b1, 4'h1, 4'd6,  4'b1011, 1'b1}; // VS, only V written
        vecs[2] = '{32'h0000_0000, 1'b0, 1'b0, 4'h4, 4'd0,  4'b1111, 1'b1}; // EQ, only Z written
        vecs[3] = '{32'h0000_0001, 1'b0, 1'b0, 4'h0, 4'd8,  4'b1111, 1'b0}; // mask 0, HI
        vecs[4] = '{32'h7FFF_FFFF, 1'b0, 1'b1, 4'hF, 4'd11, 4'b0001, 1'b1}; // LT
        vecs[5] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 4'hA, 4'd12, 4'b1011, 1'b1}; // GT
        vecs[6] = '{32'h0000_0000, 1'b0, 1'b0, 4'hC, 4'd3,  4'b0111, 1'b0}; // CC
        vecs[7] = '{32'h0000_0005, 1'b0, 1'b0, 4'hF, 4'd15, 4'b0000, 1'b0}; // NV
        sweepExp = 16'b0101_0110_0101_1010; // bit i = pass for code i, flags 1001

        ifc.upd_valid  = 1'b0;
        ifc.upd_result = '0;
        ifc.upd_carry  = 1'b0;
        ifc.upd_ovf    = 1'b0;
        ifc.upd_mask   = 4'h0;
        ifc.cond_valid = 1'b0;
        ifc.cond_code  = 4'h0;
`ifdef FLAG_SAVE_EN
        ifc.save_req    = 1'b0;
        ifc.restore_req = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_flags", ifc.flags, 0);
        check("rst_cond_done", ifc.cond_done, 0);
        check("rst_cond_pass", ifc.cond_pass, 0);
        check("rst_state", dbgState, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_upd_ready", ifc.upd_ready, 1);
        check("idle_cond_ready", ifc.cond_ready, 1);

        // Table: update, then a check against the freshly committed flags.
        for (int i = 0; i < 8; i++) begin
            doUpdate(vecs[i].result, vecs[i].carry, vecs[i].ovf, vecs[i].mask);
            check("table_flags", ifc.flags, vecs[i].expFlags);
            doCond(vecs[i].condCode);
            check("table_pass", ifc.cond_pass, vecs[i].expPass);
        end

        // Sweep every condition code against flags 1001.
        doUpdate(32'h8000_0000, 1'b0, 1'b1, 4'hF);
        check("sweep_flags", ifc.flags, 4'b1001);
        for (int code = 0; code < 16; code++) begin
            doCond(4'(code));
            check("sweep_pass", ifc.cond_pass, sweepExp[code]);
        end

        // Update and GT check arrive together: update wins, check waits.
        doUpdate(32'h1, 1'b0, 1'b0, 4'hF); // flags 0000
        ifc.upd_valid  = 1'b1;
        ifc.upd_result = 32'h0;
        ifc.upd_carry  = 1'b0;
        ifc.upd_ovf    = 1'b0;
        ifc.upd_mask   = 4'hF;
        ifc.cond_valid = 1'b1;
        ifc.cond_code  = 4'd12;
        #1;
        check("tie_upd_ready", ifc.upd_ready, 1);
        check("tie_cond_ready", ifc.cond_ready, 0);
        @(posedge clk);
        @(negedge clk);
        ifc.upd_valid = 1'b0;
        modelFlags = modelUpdate(modelFlags, 32'h0, 1'b0, 1'b0, 4'hF);
        check("tie_cond_ready_commit", ifc.cond_ready, 0);
        check("tie_no_done", ifc.cond_done, 0);
        @(negedge clk);
        check("tie_flags", ifc.flags, 4'b0100);
        check("tie_cond_ready_after", ifc.cond_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ifc.cond_valid = 1'b0;
        check("tie_done", ifc.cond_done, 1);
        check("tie_pass", ifc.cond_pass, 0);
        @(negedge clk);
        check("tie_done_drop", ifc.cond_done, 0);

        // Randomized mix of updates and checks against the model.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] r;
            case ($urandom_range(0, 3))
                0: r = 32'h0;
                1: r = 32'h8000_0000 | $urandom;
                default: r = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0)
                doUpdate(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            else
                doCond(4'($urandom_range(0, 15)));
        end

`ifdef FLAG_SAVE_EN
        // Save 0110, overwrite with 0000, restore.
        doUpdate(32'h0, 1'b1, 1'b0, 4'hF);
        check("save_setup", ifc.flags, 4'b0110);
        ifc.save_req = 1'b1;
        ifc.upd_valid = 1'b1;
        #1;
        check("save_blocks_upd", ifc.upd_ready, 0);
        @(posedge clk);
        @(negedge clk);
        ifc.save_req  = 1'b0;
        ifc.upd_valid = 1'b0;
        savedModel = modelFlags;
        doUpdate(32'h1, 1'b0, 1'b0, 4'hF);
        check("save_overwrite", ifc.flags, 4'b0000);
        ifc.restore_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.restore_req = 1'b0;
        check("restore_latency", ifc.flags, 4'b0000);
        @(negedge clk);
        modelFlags = savedModel;
        check("restore_flags", ifc.flags, 4'b0110);
`endif

        // Reset asserted mid-COMMIT drops the write and clears flags at once.
        doUpdate(32'h8000_0000, 1'b1, 1'b0, 4'hF);
        check("pre_reset_flags", ifc.flags, 4'b1010);
        ifc.upd_valid  = 1'b1;
        ifc.upd_result = 32'h0;
        ifc.upd_mask   = 4'hF;
        @(posedge clk);
        #2;
        check("in_commit", dbgState, 1);
        reset = 1'b1;
        #1;
        check("async_rst_flags", ifc.flags, 0);
        check("async_rst_done", ifc.cond_done, 0);
        check("async_rst_state", dbgState, 0);
        ifc.upd_valid = 1'b0;
        modelFlags = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        doUpdate(32'hFFFF_0000, 1'b1, 1'b1, 4'hF);
        check("post_reset_flags", ifc.flags, 4'b1011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
